// File: rtl/tm1638_phy.sv
// rtl/tm1638_phy.sv - TM1638 bit-level serial engine (SCLK timing, DIO direction, LSB-first shifting)
module tm1638_phy #(
  parameter int HALF_PERIOD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_latch,
  input  logic [7:0] data_in,
  input  logic       rw,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       sclk,
  output logic       dio_out,
  output logic       dio_oe,
  input  logic       dio_in
);

  localparam int DW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rw_q, rw_d;
  logic          oe_q, oe_d;
  logic [7:0]    dout_q, dout_d;

  // State and datapath registers; rst abandons any transfer without touching data_out beyond clearing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rw_q    <= 1'b1;
      oe_q    <= 1'b1;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state logic: latch in IDLE, half-period divider in LOW/HIGH, sample on SCLK rise, shift after HIGH.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (data_latch) begin
          shift_d = data_in;
          rw_d    = rw;
          oe_d    = rw;
          bit_d   = '0;
          div_d   = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = HIGH;
          // Read bits arrive LSB first; inserting at bit 7 and shifting right leaves them in order.
          if (!rw_q) shift_d = {dio_in, shift_q[7:1]};
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (rw_q) shift_d = {1'b1, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = IDLE;
            if (!rw_q) dout_d = shift_q;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = LOW;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign sclk     = (state_q != LOW);
  assign dio_out  = (state_q != IDLE && rw_q) ? shift_q[0] : 1'b1;
  assign dio_oe   = oe_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_tm1638_phy.sv
// tb/tb_tm1638_phy.sv - directed self-checking bench for tm1638_phy
module tb_tm1638_phy;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       latch2 = 1'b0, latch16 = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       rw = 1'b0;
  logic       dio_in = 1'b0;
  logic [7:0] dout2, dout16;
  logic       busy2, busy16, sclk2, sclk16, dout_b2, dout_b16, oe2, oe16;

  logic       sel = 1'b0;
  logic       busy_m, sclk_m, dio_m, oe_m;
  logic [7:0] dout_m;

  int checks = 0;
  int errors = 0;

  int   m_cnt, m_nrise, m_oe_bad, m_dout_chg, m_phase_bad, m_phases;
  logic [7:0] m_tx;

  always #5 clk = ~clk;

  tm1638_phy #(.HALF_PERIOD(2)) dut2 (
    .clk(clk), .rst(rst), .data_latch(latch2), .data_in(data_in), .rw(rw),
    .data_out(dout2), .busy(busy2), .sclk(sclk2), .dio_out(dout_b2),
    .dio_oe(oe2), .dio_in(dio_in)
  );

  tm1638_phy #(.HALF_PERIOD(16)) dut16 (
    .clk(clk), .rst(rst), .data_latch(latch16), .data_in(data_in), .rw(rw),
    .data_out(dout16), .busy(busy16), .sclk(sclk16), .dio_out(dout_b16),
    .dio_oe(oe16), .dio_in(dio_in)
  );

  assign busy_m = sel ? busy16  : busy2;
  assign sclk_m = sel ? sclk16  : sclk2;
  assign dio_m  = sel ? dout_b16 : dout_b2;
  assign oe_m   = sel ? oe16    : oe2;
  assign dout_m = sel ? dout16  : dout2;

  task check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_latch(input logic [7:0] d, input logic w);
    data_in = d;
    rw      = w;
    if (sel) latch16 = 1'b1; else latch2 = 1'b1;
    tick();
    latch2  = 1'b0;
    latch16 = 1'b0;
    data_in = 8'h00;
    rw      = 1'b0;
  endtask

  // Follows a transfer until busy drops; returns at the first idle sample.
  task mon(input int hp, input logic [7:0] rd, input int inj, input logic oe_exp, input logic prev0);
    logic       prev_s, run_s;
    logic [7:0] d0;
    int         run;
    m_cnt = 0; m_nrise = 0; m_tx = 8'h00; m_oe_bad = 0; m_dout_chg = 0;
    m_phase_bad = 0; m_phases = 0;
    prev_s = prev0; run_s = sclk_m; run = 0;
    d0 = dout_m;
    while (busy_m && m_cnt < 1000) begin
      m_cnt++;
      if (sclk_m && !prev_s) begin
        if (m_nrise < 8) m_tx[m_nrise] = dio_m;
        m_nrise++;
      end
      if (!sclk_m && m_nrise < 8) dio_in = rd[m_nrise];
      if (oe_m !== oe_exp) m_oe_bad++;
      if (dout_m !== d0) m_dout_chg++;
      if (sclk_m != run_s) begin
        m_phases++;
        if (run != hp) m_phase_bad++;
        run = 0;
        run_s = sclk_m;
      end
      run++;
      prev_s = sclk_m;
      if (m_cnt == inj) begin
        data_in = 8'hFF;
        rw      = 1'b0;
        latch2  = 1'b1;
      end
      tick();
      latch2 = 1'b0;
      data_in = 8'h00;
    end
    m_phases++;
    if (run != hp) m_phase_bad++;
    if (m_cnt >= 1000) check_eq("timeout", 1, 0);
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    check_eq("rst_busy", busy2, 0);
    check_eq("rst_sclk", sclk2, 1);
    check_eq("rst_dio", dout_b2, 1);
    check_eq("rst_oe", oe2, 1);
    check_eq("rst_dout", dout2, 8'h00);

    // 1: write 8F
    do_latch(8'h8F, 1'b1);
    check_eq("t1_busy_next", busy2, 1);
    mon(2, 8'h00, 0, 1'b1, 1'b1);
    check_eq("t1_len", m_cnt, 32);
    check_eq("t1_rises", m_nrise, 8);
    check_eq("t1_bits", m_tx, 8'h8F);
    check_eq("t1_oe", m_oe_bad, 0);
    check_eq("t1_phases", m_phase_bad, 0);
    check_eq("t1_nphase", m_phases, 16);
    check_eq("t1_sclk_idle", sclk2, 1);
    check_eq("t1_dio_idle", dout_b2, 1);

    // 4: re-latch in first idle cycle
    do_latch(8'h40, 1'b1);
    check_eq("t4_busy", busy2, 1);
    check_eq("t4_sclk_c1", sclk2, 0);
    tick();
    check_eq("t4_sclk_c2", sclk2, 0);
    tick();
    check_eq("t4_sclk_c3", sclk2, 1);
    mon(0, 8'h00, 0, 1'b1, 1'b0);
    check_eq("t4_len", m_cnt + 2, 32);
    check_eq("t4_bits", m_tx, 8'h40);

    // 2: read, DIO bits 0,1,0,1,1,0,1,0
    tick();
    do_latch(8'h00, 1'b0);
    check_eq("t2_oe_next", oe2, 0);
    mon(2, 8'h5A, 0, 1'b0, 1'b1);
    check_eq("t2_len", m_cnt, 32);
    check_eq("t2_oe", m_oe_bad, 0);
    check_eq("t2_dout_hold", m_dout_chg, 0);
    check_eq("t2_dout", dout2, 8'h5A);
    tick(); tick();
    check_eq("t2_oe_stay", oe2, 0);

    // 3: write C0 with ignored latch at cycle 10
    do_latch(8'hC0, 1'b1);
    mon(2, 8'h00, 10, 1'b1, 1'b1);
    check_eq("t3_len", m_cnt, 32);
    check_eq("t3_bits", m_tx, 8'hC0);
    check_eq("t3_oe", m_oe_bad, 0);
    check_eq("t3_dout", dout2, 8'h5A);

    // 5: reset during a read at cycle 13
    tick();
    do_latch(8'h5A, 1'b0);
    for (int i = 1; i < 13; i++) tick();
    check_eq("t5_busy_pre", busy2, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5_busy", busy2, 0);
    check_eq("t5_sclk", sclk2, 1);
    check_eq("t5_dio", dout_b2, 1);
    check_eq("t5_oe", oe2, 1);
    check_eq("t5_dout", dout2, 8'h00);
    do_latch(8'hA5, 1'b1);
    mon(2, 8'h00, 0, 1'b1, 1'b1);
    check_eq("t5_len", m_cnt, 32);
    check_eq("t5_bits", m_tx, 8'hA5);

    // 6: HALF_PERIOD=16
    sel = 1'b1;
    tick();
    do_latch(8'h3C, 1'b1);
    mon(16, 8'h00, 0, 1'b1, 1'b1);
    check_eq("t6_len", m_cnt, 256);
    check_eq("t6_phases", m_phase_bad, 0);
    check_eq("t6_nphase", m_phases, 16);
    check_eq("t6_bits", m_tx, 8'h3C);
    check_eq("t6_sclk_idle", sclk16, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
